// File: rtl/formula_sample_checker_if.sv
// Link between the sample checker and the combinational formula under test:
// the assignment vector with its valid flag out, the formula result back.
interface formula_sample_checker_if #(
    parameter int NUM_IN = 56
);
    logic [NUM_IN-1:0] vec_out;
    logic              vec_valid;
    logic              formula_out;

    modport master (output vec_out, output vec_valid, input formula_out);
    modport slave  (input vec_out, input vec_valid, output formula_out);
endinterface

// File: rtl/formula_sample_checker.sv
// Drives LFSR-generated assignments into a Skolem formula block, counts vectors
// for which the formula evaluates false, and keeps the first failing vector.
module formula_sample_checker #(
    parameter int          NUM_IN      = 56,
    parameter int          NUM_SAMPLES = 1024,
    parameter int          CNT_W       = 16,
    parameter logic [63:0] DEF_SEED    = 64'hACE1_1234_5678_9ABC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_pause,
    input  logic [63:0]              i_seed,
    formula_sample_checker_if.master fx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [CNT_W-1:0]         o_fail_count,
    output logic [NUM_IN-1:0]        o_first_fail_vec,
    output logic                     o_first_fail_vld
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam int              ICNT_W     = $clog2(NUM_SAMPLES + 1);
    localparam logic [ICNT_W-1:0] ISSUE_LAST = ICNT_W'(NUM_SAMPLES);
    // Right-shift Galois taps for x^64 + x^63 + x^61 + x^60 + 1.
    localparam logic [63:0]     TAPS       = 64'hD800_0000_0000_0000;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_lfsr;
    logic [ICNT_W-1:0]   r_issue_cnt;
    logic [NUM_IN-1:0]   r_vec;
    logic                r_vec_valid;
    logic [CNT_W-1:0]    r_fail_count;
    logic [NUM_IN-1:0]   r_first_fail_vec;
    logic                r_first_fail_vld;
    logic [63:0]         w_seed_eff;
    logic                w_accept;
    logic                w_issue;
    logic                w_fail_hit;

    function automatic logic [63:0] f_lfsr_step(input logic [63:0] s);
        return {1'b0, s[63:1]} ^ (s[0] ? TAPS : 64'h0);
    endfunction

    assign w_seed_eff = (i_seed == 64'h0) ? DEF_SEED : i_seed;
    assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start && !i_abort;
    assign w_issue    = (r_state == ST_RUN) && !i_abort && !i_pause && (r_issue_cnt != ISSUE_LAST);
    assign w_fail_hit = r_vec_valid && !fx.formula_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (i_start) w_state_nxt = ST_RUN;
                ST_RUN:           if (r_issue_cnt == ISSUE_LAST) w_state_nxt = ST_DRAIN;
                ST_DRAIN:         w_state_nxt = ST_DONE;
                default:          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The accepting edge already issues the seed itself, so vec_valid rises
    // in the first RUN cycle and the LFSR register always holds the next vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr           <= DEF_SEED;
            r_issue_cnt      <= '0;
            r_vec            <= '0;
            r_vec_valid      <= 1'b0;
            r_fail_count     <= '0;
            r_first_fail_vec <= '0;
            r_first_fail_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lfsr      <= f_lfsr_step(w_seed_eff);
                r_vec       <= w_seed_eff[NUM_IN-1:0];
                r_vec_valid <= 1'b1;
                r_issue_cnt <= ICNT_W'(1);
            end else if (w_issue) begin
                r_lfsr      <= f_lfsr_step(r_lfsr);
                r_vec       <= r_lfsr[NUM_IN-1:0];
                r_vec_valid <= 1'b1;
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end else begin
                r_vec_valid <= 1'b0;
            end

            if (w_accept) begin
                r_fail_count     <= '0;
                r_first_fail_vld <= 1'b0;
            end else if (w_fail_hit) begin
                if (r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
                if (!r_first_fail_vld) begin
                    r_first_fail_vec <= r_vec;
                    r_first_fail_vld <= 1'b1;
                end
            end
        end
    end

    assign fx.vec_out       = r_vec;
    assign fx.vec_valid     = r_vec_valid;
    assign o_busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done           = (r_state == ST_DONE);
    assign o_pass           = o_done && (r_fail_count == '0);
    assign o_fail_count     = r_fail_count;
    assign o_first_fail_vec = r_first_fail_vec;
    assign o_first_fail_vld = r_first_fail_vld;
endmodule
